// File: rtl/k_dsp_pkg.sv
// Shared types and constants for the program loader.
// K_LOADER_CHECKSUM_EN adds the trailing checksum state StChk.
package k_dsp_pkg;

  localparam int unsigned HdrW      = 16;
  localparam int unsigned WordBytes = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StRecv,
    StWrite,
`ifdef K_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StError
  } state_e;

  function automatic logic accepts_bytes(state_e s);
`ifdef K_LOADER_CHECKSUM_EN
    return (s == StHdr) || (s == StRecv) || (s == StChk);
`else
    return (s == StHdr) || (s == StRecv);
`endif
  endfunction

endpackage

// File: rtl/k_byte_packer.sv
// Big-endian byte-to-word packer: shift register plus byte counter.
// word_valid_o pulses on the byte that completes a word; word_o is that word.
module k_byte_packer
  import k_dsp_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   word_valid_o,
  output logic [WordBytes*8-1:0] word_o
);

  localparam int unsigned WordW = WordBytes * 8;
  localparam int unsigned CntW  = $clog2(WordBytes);

  // Only the first three bytes need storage; the fourth arrives with the pulse.
  logic [WordW-9:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign word_o       = {shift_q, byte_data_i};
  assign word_valid_o = byte_valid_i && (cnt_q == CntW'(WordBytes - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o[WordW-9:0];
      cnt_d   = word_valid_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/k_program_loader.sv
// Streams a length-prefixed program into instruction memory, then releases the core.
// Define K_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module k_program_loader
  import k_dsp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_e              state_q, state_d;
  logic                hdr_cnt_q, hdr_cnt_d;
  logic [HdrW-1:0]     n_q, n_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                run_q, run_d, busy_q, busy_d, err_q, err_d;
`ifdef K_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  localparam state_e   StTail = StChk;
`else
  localparam state_e   StTail = StDone;
`endif

  logic            xfer, pk_clear, pk_valid;
  logic [31:0]     pk_word;
  logic [HdrW-1:0] n_full;
  logic [ADDR_W:0] words_inc;

  assign xfer      = in_valid && in_ready_q;
  assign n_full    = {n_q[HdrW-1:8], in_data};
  assign words_inc = words_q + 1'b1;
  assign pk_clear  = start && (state_q == StIdle || state_q == StDone || state_q == StError);

  k_byte_packer u_packer (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (pk_clear),
    .byte_valid_i (xfer && (state_q == StRecv)),
    .byte_data_i  (in_data),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    n_d       = n_q;
    words_d   = words_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef K_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (xfer && (state_q == StHdr || state_q == StRecv)) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d   = StHdr;
          hdr_cnt_d = 1'b0;
          words_d   = '0;
`ifdef K_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      StHdr: begin
        if (xfer) begin
          if (!hdr_cnt_q) begin
            n_d[HdrW-1:8] = in_data;
            hdr_cnt_d     = 1'b1;
          end else begin
            n_d = n_full;
            if (32'(n_full) > MAX_WORDS) state_d = StError;
            else if (n_full == '0)       state_d = StTail;
            else                         state_d = StRecv;
          end
        end
      end
      StRecv: begin
        // Capture on the completing byte so the write appears as a registered strobe.
        if (pk_valid) begin
          state_d = StWrite;
          we_d    = 1'b1;
          addr_d  = words_q[ADDR_W-1:0];
          wdata_d = pk_word;
        end
      end
      StWrite: begin
        words_d = words_inc;
        state_d = (32'(words_inc) < 32'(n_q)) ? StRecv : StTail;
      end
`ifdef K_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) state_d = (in_data == csum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase

    in_ready_d = accepts_bytes(state_d);
    busy_d     = (state_d == StHdr) || (state_d == StRecv) || (state_d == StWrite);
    run_d      = (state_d == StDone);
    err_d      = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hdr_cnt_q  <= 1'b0;
      n_q        <= '0;
      words_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef K_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      n_q        <= n_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
`ifdef K_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_run     = run_q;
  assign busy         = busy_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_k_program_loader.sv
// Scoreboard bench for k_program_loader; expected writes are queued by the stimulus
// and checked by a monitor on every imem_we. Honours K_LOADER_CHECKSUM_EN.
module tb_k_program_loader;

  localparam int unsigned ADDR_W = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, imem_we, core_run, busy, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_writes = 0;
  wr_t exp_q[$];

  k_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_run     (core_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      wr_t e;
      n_writes++;
      check("in_ready_low_in_write", {31'b0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {24'b0, imem_addr}, {24'b0, e.addr});
        check("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int guard = 0;
    if (gappy) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 50) begin
        check("send_byte_timeout", 32'd1, 32'd0);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Sends the bytes, plus the XOR checksum when the checksum build is selected.
  task automatic send_stream(input byte_q_t bs, input bit gappy);
    logic [7:0] x = '0;
    foreach (bs[i]) begin
      send_byte(bs[i], gappy);
      x ^= bs[i];
    end
`ifdef K_LOADER_CHECKSUM_EN
    send_byte(x, gappy);
`endif
  endtask

  task automatic wait_end();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (core_run || error) return;
    end
    check("wait_end_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    check({tag, "_imem_addr"}, {24'b0, imem_addr}, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_core_run"}, {31'b0, core_run}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
    check({tag, "_words"}, {23'b0, words_loaded}, 32'd0);
  endtask

  initial begin
    int w0;
    byte_q_t s;

    tick();
    tick();
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Bytes in IDLE are ignored.
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    tick();

    // Two-word load.
    exp_q.push_back('{8'd0, 32'hDEADBEEF});
    exp_q.push_back('{8'd1, 32'h12345678});
    pulse_start();
    @(negedge clk);
    check("hdr_busy", {31'b0, busy}, 32'd1);
    check("hdr_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    send_stream(s, 1'b0);
    wait_end();
    check("n2_core_run", {31'b0, core_run}, 32'd1);
    check("n2_error", {31'b0, error}, 32'd0);
    check("n2_words", {23'b0, words_loaded}, 32'd2);
    check("n2_pending", 32'(exp_q.size()), 32'd0);
    check("n2_writes", 32'(n_writes), 32'd2);

    // DONE holds and ignores bytes.
    tick();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    tick();
    @(negedge clk);
    in_valid = 1'b0;
    check("done_hold_run", {31'b0, core_run}, 32'd1);
    check("done_in_ready", {31'b0, in_ready}, 32'd0);
    check("done_words", {23'b0, words_loaded}, 32'd2);
    tick();

    // Empty program.
    w0 = n_writes;
    pulse_start();
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    wait_end();
    check("n0_core_run", {31'b0, core_run}, 32'd1);
    check("n0_words", {23'b0, words_loaded}, 32'd0);
    check("n0_no_writes", 32'(n_writes - w0), 32'd0);
    tick();

    // Oversized program.
    w0 = n_writes;
    pulse_start();
    s = '{8'h01, 8'h01};
    foreach (s[i]) send_byte(s[i], 1'b0);
    wait_end();
    tick();
    @(negedge clk);
    check("n257_error", {31'b0, error}, 32'd1);
    check("n257_in_ready", {31'b0, in_ready}, 32'd0);
    check("n257_core_run", {31'b0, core_run}, 32'd0);
    check("n257_no_writes", 32'(n_writes - w0), 32'd0);
    tick();

    // Three words with random gaps; a start pulse mid-load must be ignored.
    exp_q.push_back('{8'd0, 32'h11223344});
    exp_q.push_back('{8'd1, 32'hA5A55A5A});
    exp_q.push_back('{8'd2, 32'h0F0E0D0C});
    pulse_start();
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (s[i]) send_byte(s[i], 1'b1);
    pulse_start();
    @(negedge clk);
    check("busy_start_ignored", {31'b0, busy}, 32'd1);
    tick();
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
          8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h0F, 8'h0E, 8'h0D, 8'h0C};
    // Header and first word already sent; finish the stream with the checksum seeded.
    begin
      logic [7:0] x = '0;
      foreach (s[i]) begin
        x ^= s[i];
        if (i >= 6) send_byte(s[i], 1'b1);
      end
`ifdef K_LOADER_CHECKSUM_EN
      send_byte(x, 1'b1);
`endif
    end
    wait_end();
    check("n3_core_run", {31'b0, core_run}, 32'd1);
    check("n3_words", {23'b0, words_loaded}, 32'd3);
    check("n3_pending", 32'(exp_q.size()), 32'd0);
    tick();

    // Reset mid-word aborts cleanly.
    w0 = n_writes;
    pulse_start();
    s = '{8'h00, 8'h02, 8'hCA, 8'hFE};
    foreach (s[i]) send_byte(s[i], 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    tick();
    tick();
    check("midreset_no_writes", 32'(n_writes - w0), 32'd0);

    exp_q.push_back('{8'd0, 32'hCAFEF00D});
    pulse_start();
    s = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_stream(s, 1'b0);
    wait_end();
    check("reload_core_run", {31'b0, core_run}, 32'd1);
    check("reload_words", {23'b0, words_loaded}, 32'd1);
    check("reload_pending", 32'(exp_q.size()), 32'd0);
    tick();

`ifdef K_LOADER_CHECKSUM_EN
    // Explicit checksum good/bad.
    exp_q.push_back('{8'd0, 32'h01020304});
    pulse_start();
    s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    foreach (s[i]) send_byte(s[i], 1'b0);
    wait_end();
    check("csum_ok_run", {31'b0, core_run}, 32'd1);
    check("csum_ok_err", {31'b0, error}, 32'd0);
    tick();
    exp_q.push_back('{8'd0, 32'h01020304});
    pulse_start();
    s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    foreach (s[i]) send_byte(s[i], 1'b0);
    wait_end();
    check("csum_bad_err", {31'b0, error}, 32'd1);
    check("csum_bad_run", {31'b0, core_run}, 32'd0);
    check("csum_pending", 32'(exp_q.size()), 32'd0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/k_program_loader.md
K_PROGRAM_LOADER -- requirements
Module: k_program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: instruction-memory address width.
REQ-002 SHALL have parameter MAX_WORDS, default 2**ADDR_W: largest accepted program length.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that arms a load; sampled only in IDLE, DONE or ERROR.
REQ-006 SHALL have port in_data, input, 8: byte stream in.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_ready, output, 1: loader accepts a byte.
REQ-009 SHALL have port imem_we, output, 1: instruction-memory write strobe.
REQ-010 SHALL have port imem_addr, output, ADDR_W: write address.
REQ-011 SHALL have port imem_wdata, output, 32: write word.
REQ-012 SHALL have port core_run, output, 1: releases the program counter; high only in DONE.
REQ-013 SHALL have port busy, output, 1: high in HDR, RECV and WRITE.
REQ-014 SHALL have port error, output, 1: high in ERROR.
REQ-015 SHALL have port words_loaded, output, ADDR_W+1: count of words written in the current load.

Function
REQ-016 SHALL transfer a byte only on a cycle where in_valid and in_ready are both high.
REQ-017 SHALL implement states IDLE, HDR, RECV, WRITE, CHK, DONE and ERROR.
REQ-018 SHALL go from IDLE, DONE or ERROR to HDR on start, clearing words_loaded and the byte counter.
REQ-019 SHALL, in HDR, accept 2 bytes as word count N (big-endian, 16-bit).
REQ-020 SHALL go to ERROR when N > MAX_WORDS.
REQ-021 SHALL go from HDR to CHK (macro on) or DONE (macro off) when N == 0, with no writes.
REQ-022 SHALL, in RECV, assemble 4 bytes big-endian (first byte -> bits 31:24).
REQ-023 SHALL go to WRITE on the cycle after the 4th byte is accepted.
REQ-024 SHALL, in WRITE, hold imem_we high exactly 1 cycle, with imem_addr = words_loaded[ADDR_W-1:0] and imem_wdata = the assembled word.
REQ-025 SHALL increment words_loaded at the end of each WRITE cycle.
REQ-026 SHALL go from WRITE back to RECV while words_loaded < N.
REQ-027 SHALL go from WRITE to CHK or DONE after the Nth write.
REQ-028 SHALL drive in_ready high only in HDR, RECV and CHK, and low in WRITE (1 bubble per word).
REQ-029 SHALL leave imem_addr and imem_wdata holding their last values when imem_we is low.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL ignore bytes offered in IDLE, DONE or ERROR (in_ready low).
REQ-032 SHALL hold in DONE and ERROR until start or reset.

Reset
REQ-033 SHALL, on reset, enter IDLE and clear in_ready, imem_we, imem_addr, imem_wdata, core_run, busy, error and words_loaded to 0.
REQ-034 SHALL, on reset asserted mid-load, abort without completing a partial word and without any further imem_we.
REQ-035 SHALL give reset priority over start and in_valid.

Configuration
REQ-036 SHALL, when K_LOADER_CHECKSUM_EN is defined, accept in CHK one trailing byte compared with the XOR of all header and payload bytes: equal -> DONE, unequal -> ERROR.
REQ-037 SHALL, when K_LOADER_CHECKSUM_EN is undefined, omit the CHK state and checksum register; the state after the last WRITE or an N==0 header is DONE.

Structure
REQ-038 SHALL place the state enum, the 16-bit header width and the word size of 4 bytes in shared package k_dsp_pkg.
REQ-039 SHALL implement byte-to-word assembly as sub-module k_byte_packer (shift register plus byte counter, word_valid pulse).

Verification
REQ-040 SHALL cover: N=2, bytes 00 02 DE AD BE EF 12 34 56 78 -> writes addr0=DEADBEEF, addr1=12345678; then core_run=1, words_loaded=2.
REQ-041 SHALL cover: header 00 00 -> no imem_we; DONE immediately (macro off) or after checksum 00 (macro on).
REQ-042 SHALL cover: ADDR_W=8, header 01 01 (N=257) -> error=1, no writes, in_ready=0.
REQ-043 SHALL cover: in_valid toggling randomly during a 3-word load -> identical writes; in_ready low for each WRITE cycle.
REQ-044 SHALL cover: reset after 2 payload bytes -> IDLE, all outputs 0; a new start plus a full stream loads correctly.
REQ-045 SHALL cover, with the macro on, N=1 word 01020304: checksum 00^01^01^02^03^04=05 -> DONE; checksum 06 -> ERROR, core_run=0.
